// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one IMEM request at a time and
// holds the fetched instruction for decode until it is accepted or redirected away.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_timeout
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_HOLD,
    ST_ERR
  } state_t;

  // A zero timeout still needs a 1-bit counter so the declarations stay legal.
  localparam int unsigned      CNT_W       = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic [31:0]        w_pc_plus4;
  logic [31:0]        w_redirect_target;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_capture;
  logic [31:0]        r_if_instr;
  logic [31:0]        r_if_pc;
  logic [31:0]        r_if_pc_plus4;

  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign w_cnt_inc         = r_wait_cnt + 1'b1;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_wait_cnt;
    w_capture   = 1'b0;

    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_pc_nxt    = w_pc_plus4;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end else if (TIMEOUT_EN) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == TIMEOUT_VAL) w_state_nxt = ST_ERR;
        end
      end
      ST_HOLD: begin
        if (!stall) w_state_nxt = ST_REQ;
      end
      ST_ERR: w_state_nxt = ST_ERR;
    endcase

    // Redirect overrides everything short of the fault state, including a same-cycle ack.
    if (redirect_valid && (r_state != ST_ERR)) begin
      w_pc_nxt    = w_redirect_target;
      w_cnt_nxt   = '0;
      w_capture   = 1'b0;
      w_state_nxt = ST_REQ;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_wait_cnt    <= '0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_wait_cnt <= w_cnt_nxt;
      if (w_capture) begin
        r_if_instr    <= imem_rdata;
        r_if_pc       <= r_pc;
        r_if_pc_plus4 <= w_pc_plus4;
      end
    end
  end

  // The held instruction is valid exactly while in HOLD; the fault flag is the ERR state.
  assign imem_req      = (r_state == ST_REQ);
  assign imem_addr     = r_pc;
  assign if_valid      = (r_state == ST_HOLD);
  assign if_instr      = r_if_instr;
  assign if_pc         = r_if_pc;
  assign if_pc_plus4   = r_if_pc_plus4;
  assign fetch_timeout = (r_state == ST_ERR);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a scoreboard queue of expected held
// instructions is filled when IMEM acks and drained when decode consumes.
module tb_pc_fetch_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: default parameters (RESET_PC=0, TIMEOUT_CYCLES=16)
  logic        rst_n, stall, redirect_valid, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid, fetch_timeout;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc_plus4;

  // Second DUT: wrap-around reset PC and timeout disabled
  logic        rst2_n, stall2, rv2, ack2;
  logic [31:0] rpc2, rdata2;
  logic        req2, valid2, to2;
  logic [31:0] addr2, instr2, pc2, pc4_2;

  pc_fetch_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .fetch_timeout(fetch_timeout)
  );

  pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(0)) u_dut_wrap (
    .clk(clk), .rst_n(rst2_n), .stall(stall2),
    .redirect_valid(rv2), .redirect_pc(rpc2),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .if_valid(valid2), .if_instr(instr2), .if_pc(pc2),
    .if_pc_plus4(pc4_2), .fetch_timeout(to2)
  );

  int          checks = 0;
  int          errors = 0;
  int          valid_cycles;
  int          req_cycles;
  logic [31:0] exp_pc;
  exp_t        sb[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    sb.delete();
    exp_pc = 32'h0; valid_cycles = 0; req_cycles = 0;
    cyc();  // BOOT -> REQ
  endtask

  // One cycle of a zero-wait IMEM and decode stage: compare the held instruction with
  // the scoreboard head, answer a request, then advance the clock.
  task automatic service(input bit do_ack, input bit do_stall);
    exp_t e;
    if (if_valid === 1'b1) begin
      valid_cycles++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: if_valid=1 if_pc=%h but nothing expected", if_pc);
      end else begin
        e = sb[0];
        if ({if_pc, if_instr, if_pc_plus4} !== {e.pc, e.instr, e.pc4}) begin
          errors++;
          $display("FAIL held_instr: got pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                   if_pc, if_instr, if_pc_plus4, e.pc, e.instr, e.pc4);
        end
        if (!do_stall) void'(sb.pop_front());
      end
    end
    imem_ack = 1'b0;
    if (imem_req === 1'b1) begin
      req_cycles++;
      checks++;
      if (imem_addr !== exp_pc) begin
        errors++;
        $display("FAIL req_addr: got %h expected %h", imem_addr, exp_pc);
      end
      if (do_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = instr_of(exp_pc);
        sb.push_back('{exp_pc, instr_of(exp_pc), exp_pc + 32'd4});
        exp_pc = exp_pc + 32'd4;
      end
    end
    stall = do_stall;
    cyc();
  endtask

  task automatic test_reset();
    reset_dut();
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({imem_req, if_valid, fetch_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: req/valid/timeout=%b expected 000", {imem_req, if_valid, fetch_timeout});
    end
    checks++;
    if ({if_instr, if_pc, if_pc_plus4, imem_addr} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: instr=%h pc=%h pc4=%h addr=%h expected all 0",
               if_instr, if_pc, if_pc_plus4, imem_addr);
    end
    rst_n = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req: imem_req=%b expected 0 in BOOT", imem_req);
    end
  endtask

  task automatic test_stream();
    reset_dut();
    for (int i = 0; i < 6; i++) service(1'b1, 1'b0);
    checks++;
    if (valid_cycles != 3 || req_cycles != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_rate: valid_cycles=%0d req_cycles=%0d left=%0d expected 3 3 0",
               valid_cycles, req_cycles, sb.size());
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL stream_next: req=%b addr=%h expected 1 0000000c", imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    reset_dut();
    service(1'b1, 1'b0);
    service(1'b0, 1'b0);
    service(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h4) begin
        errors++;
        $display("FAIL stall_hold[%0d]: req=%b valid=%b if_pc=%h expected 0 1 00000004",
                 i, imem_req, if_valid, if_pc);
      end
      service(1'b0, 1'b1);
    end
    service(1'b0, 1'b0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h valid=%b expected 1 00000008 0",
               imem_req, imem_addr, if_valid);
    end
  endtask

  task automatic test_redirect();
    reset_dut();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    exp_pc = 32'h100;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_req: req=%b addr=%h valid=%b expected 1 00000100 0",
               imem_req, imem_addr, if_valid);
    end
    service(1'b1, 1'b0);
    service(1'b0, 1'b0);
    service(1'b1, 1'b0);
    // redirect while holding with stall=1: the instruction must be dropped
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; stall = 1'b1;
    cyc();
    redirect_valid = 1'b0; stall = 1'b0;
    void'(sb.pop_front());
    exp_pc = 32'h200;
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_hold: valid=%b req=%b addr=%h expected 0 1 00000200",
               if_valid, imem_req, imem_addr);
    end
    // redirect taken straight out of BOOT
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
    cyc();
    redirect_valid = 1'b0;
    sb.delete();
    exp_pc = 32'h40; valid_cycles = 0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_boot: req=%b addr=%h expected 1 00000040", imem_req, imem_addr);
    end
    service(1'b1, 1'b0);
    service(1'b0, 1'b0);
    checks++;
    if (valid_cycles != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL redir_boot_fetch: valid_cycles=%0d left=%0d expected 1 0", valid_cycles, sb.size());
    end
  endtask

  task automatic test_wrap();
    rst2_n = 1'b0; stall2 = 1'b0; rv2 = 1'b0; rpc2 = '0; ack2 = 1'b0; rdata2 = '0;
    cyc(); cyc();
    rst2_n = 1'b1;
    cyc();
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req: req=%b addr=%h expected 1 fffffffc", req2, addr2);
    end
    ack2 = 1'b1; rdata2 = instr_of(32'hFFFF_FFFC);
    cyc();
    ack2 = 1'b0;
    checks++;
    if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pc4_2 !== 32'h0 || instr2 !== instr_of(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap_held: valid=%b pc=%h pc4=%h instr=%h expected 1 fffffffc 00000000 %h",
               valid2, pc2, pc4_2, instr2, instr_of(32'hFFFF_FFFC));
    end
    cyc();
    checks++;
    if (req2 !== 1'b1 || addr2 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next: req=%b addr=%h expected 1 00000000", req2, addr2);
    end
    // timeout disabled: an unanswered request must wait forever
    for (int i = 0; i < 40; i++) cyc();
    checks++;
    if (req2 !== 1'b1 || to2 !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: req=%b timeout=%b expected 1 0", req2, to2);
    end
  endtask

  task automatic test_timeout();
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (imem_req !== 1'b1 || fetch_timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait[%0d]: req=%b timeout=%b expected 1 0", i, imem_req, fetch_timeout);
      end
      cyc();
    end
    checks++;
    if (fetch_timeout !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: timeout=%b req=%b valid=%b expected 1 0 0",
               fetch_timeout, imem_req, if_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80; imem_ack = 1'b1; stall = 1'b1;
    cyc(); cyc();
    redirect_valid = 1'b0; imem_ack = 1'b0; stall = 1'b0;
    checks++;
    if (fetch_timeout !== 1'b1 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL err_sticky: timeout=%b req=%b addr=%h expected 1 0 00000000",
               fetch_timeout, imem_req, imem_addr);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++;
    if (fetch_timeout !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL err_reset: timeout=%b addr=%h expected 0 00000000", fetch_timeout, imem_addr);
    end
  endtask

  task automatic test_reset_in_hold();
    reset_dut();
    service(1'b1, 1'b0);
    stall = 1'b1; rst_n = 1'b0;
    cyc();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL hold_reset: valid=%b req=%b addr=%h if_pc=%h expected 0 0 00000000 00000000",
               if_valid, imem_req, imem_addr, if_pc);
    end
    rst_n = 1'b1; stall = 1'b0;
    cyc();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL hold_resume: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  initial begin
    rst2_n = 1'b0; stall2 = 1'b0; rv2 = 1'b0; rpc2 = '0; ack2 = 1'b0; rdata2 = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_timeout();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
